// File: rtl/flt_env_vca.sv
// rtl/flt_env_vca.sv - ADSR envelope generator and VCA stage after the FLT filter.
// Rate/level registers share the FLT parameter bus; output is sample * level >> 16.
module flt_env_vca #(
   parameter int unsigned          ADDR_WIDTH = 5,
   parameter int unsigned          MEM_WIDTH  = 32,
   parameter int unsigned          IN_WIDTH   = 24,
   parameter int unsigned          OUT_WIDTH  = 24,
   parameter int unsigned          LVL_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 5'd28
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RBI,
   input  logic                  WrEn_SI,
   input  logic [ADDR_WIDTH-1:0] Addr_DI,
   input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
   input  logic                  Gate_SI,
   input  logic [IN_WIDTH-1:0]   ENV_In_DI,
   output logic [OUT_WIDTH-1:0]  ENV_Out_DO,
   output logic [LVL_WIDTH-1:0]  Env_Level_DO,
   output logic                  Busy_SO
);

   typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

   localparam logic [LVL_WIDTH-1:0] LVL_MAX = '1;

   state_t                 state_q;
   logic [LVL_WIDTH-1:0]   a_q, d_q, s_q, r_q;
   logic [LVL_WIDTH-1:0]   level_q;
   logic                   gate_q;
   logic                   busy_q;
   logic [OUT_WIDTH-1:0]   out_q;

   logic                   rise;
   logic [ADDR_WIDTH-1:0]  wr_off;
   logic                   wr_hit;
   logic [LVL_WIDTH:0]     atk_sum;
   logic [LVL_WIDTH:0]     dec_thr;
   logic signed [IN_WIDTH+LVL_WIDTH:0] prod;
   logic                   unused_bits;

   assign rise   = Gate_SI & ~gate_q;
   assign wr_off = Addr_DI - BASE_ADDR;
   assign wr_hit = WrEn_SI && (wr_off < ADDR_WIDTH'(4));

   // 17-bit sums so the saturation/threshold tests cannot wrap
   assign atk_sum = {1'b0, level_q} + {1'b0, a_q};
   assign dec_thr = {1'b0, s_q} + {1'b0, d_q};

   // level is zero-extended so it multiplies as a positive gain
   assign prod = $signed(ENV_In_DI) * $signed({1'b0, level_q});

   assign unused_bits = ^{prod[IN_WIDTH+LVL_WIDTH], prod[LVL_WIDTH-1:0],
                          PAR_In_DI[MEM_WIDTH-1:LVL_WIDTH]};

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_q <= IDLE;
         a_q     <= LVL_MAX;
         d_q     <= LVL_MAX;
         s_q     <= LVL_MAX;
         r_q     <= LVL_MAX;
         level_q <= '0;
         gate_q  <= 1'b0;
         busy_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         gate_q <= Gate_SI;
         out_q  <= prod[LVL_WIDTH+OUT_WIDTH-1:LVL_WIDTH];

         if (wr_hit) begin
            case (wr_off[1:0])
               2'd0:    a_q <= PAR_In_DI[LVL_WIDTH-1:0];
               2'd1:    d_q <= PAR_In_DI[LVL_WIDTH-1:0];
               2'd2:    s_q <= PAR_In_DI[LVL_WIDTH-1:0];
               default: r_q <= PAR_In_DI[LVL_WIDTH-1:0];
            endcase
         end

         case (state_q)
            IDLE: begin
               level_q <= '0;
               if (rise) begin
                  state_q <= ATTACK;
                  busy_q  <= 1'b1;
               end
            end
            ATTACK: begin
               if (!Gate_SI) begin
                  state_q <= RELEASE;
               end else if (atk_sum >= {1'b0, LVL_MAX}) begin
                  level_q <= LVL_MAX;
                  state_q <= DECAY;
               end else begin
                  level_q <= atk_sum[LVL_WIDTH-1:0];
               end
            end
            DECAY: begin
               if (!Gate_SI) begin
                  state_q <= RELEASE;
               end else if ({1'b0, level_q} <= dec_thr) begin
                  level_q <= s_q;
                  state_q <= SUSTAIN;
               end else begin
                  level_q <= level_q - d_q;
               end
            end
            SUSTAIN: begin
               level_q <= s_q;
               if (!Gate_SI) state_q <= RELEASE;
            end
            RELEASE: begin
               // retrigger restarts the attack from the current level
               if (rise) begin
                  state_q <= ATTACK;
               end else if (level_q <= r_q) begin
                  level_q <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  level_q <= level_q - r_q;
               end
            end
            default: begin
               state_q <= IDLE;
               level_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ENV_Out_DO   = out_q;
   assign Env_Level_DO = level_q;
   assign Busy_SO      = busy_q;

endmodule

// File: tb/tb_flt_env_vca.sv
// tb/tb_flt_env_vca.sv - directed self-checking bench for flt_env_vca.
module tb_flt_env_vca;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [4:0]  addr;
   logic [31:0] par;
   logic        gate;
   logic [23:0] env_in;
   logic [23:0] env_out;
   logic [15:0] level;
   logic        busy;

   int passed = 0;
   int total  = 0;

   flt_env_vca dut (
      .Clk_CI      (clk),
      .Rst_RBI     (rst_n),
      .WrEn_SI     (wr_en),
      .Addr_DI     (addr),
      .PAR_In_DI   (par),
      .Gate_SI     (gate),
      .ENV_In_DI   (env_in),
      .ENV_Out_DO  (env_out),
      .Env_Level_DO(level),
      .Busy_SO     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      wr_en = 1'b1;
      addr  = a;
      par   = d;
      tick();
      wr_en = 1'b0;
      addr  = 5'd0;
      par   = 32'd0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_en = 1'b0; addr = 5'd0; par = 32'd0; gate = 1'b0; env_in = 24'h100000;
      #3;
      total++; if (env_out !== 24'h0) $display("FAIL reset_out got=%h exp=%h", env_out, 24'h0); else passed++;
      total++; if (level !== 16'h0) $display("FAIL reset_level got=%h exp=%h", level, 16'h0); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_default_regs();
      gate = 1'b1;
      tick();
      total++; if (level !== 16'h0 || busy !== 1'b1) $display("FAIL t1_attack_entry level=%h busy=%b exp=0000/1", level, busy); else passed++;
      tick();
      total++; if (level !== 16'hFFFF) $display("FAIL t1_attack_sat got=%h exp=FFFF", level); else passed++;
      tick();
      total++; if (level !== 16'hFFFF) $display("FAIL t1_sustain got=%h exp=FFFF", level); else passed++;
      total++; if (env_out !== 24'h0FFFF0) $display("FAIL t1_out got=%h exp=0FFFF0", env_out); else passed++;
      gate = 1'b0;
      tick();
      tick();
      total++; if (level !== 16'h0 || busy !== 1'b0) $display("FAIL t1_release level=%h busy=%b exp=0000/0", level, busy); else passed++;
      tick();
      total++; if (env_out !== 24'h0) $display("FAIL t1_out_zero got=%h exp=000000", env_out); else passed++;
   endtask

   task automatic test_adsr();
      wr(5'd28, 32'h0000_1000);
      wr(5'd29, 32'h0000_0800);
      wr(5'd30, 32'h0000_8000);
      wr(5'd31, 32'h0000_0400);
      gate = 1'b1;
      tick();
      repeat (15) tick();
      total++; if (level !== 16'hF000) $display("FAIL t2_attack15 got=%h exp=F000", level); else passed++;
      tick();
      total++; if (level !== 16'hFFFF) $display("FAIL t2_attack16 got=%h exp=FFFF", level); else passed++;
      repeat (15) tick();
      total++; if (level !== 16'h87FF) $display("FAIL t2_decay15 got=%h exp=87FF", level); else passed++;
      tick();
      total++; if (level !== 16'h8000) $display("FAIL t2_decay16 got=%h exp=8000", level); else passed++;
      repeat (3) tick();
      total++; if (level !== 16'h8000) $display("FAIL t2_sustain got=%h exp=8000", level); else passed++;
      total++; if (env_out !== 24'h080000) $display("FAIL t2_out got=%h exp=080000", env_out); else passed++;
      gate = 1'b0;
      tick();
      total++; if (level !== 16'h8000 || busy !== 1'b1) $display("FAIL t2_rel_entry level=%h busy=%b exp=8000/1", level, busy); else passed++;
      repeat (31) tick();
      total++; if (level !== 16'h0400 || busy !== 1'b1) $display("FAIL t2_rel31 level=%h busy=%b exp=0400/1", level, busy); else passed++;
      tick();
      total++; if (level !== 16'h0 || busy !== 1'b0) $display("FAIL t2_rel32 level=%h busy=%b exp=0000/0", level, busy); else passed++;
   endtask

   task automatic test_early_release();
      gate = 1'b1;
      tick();
      repeat (5) tick();
      total++; if (level !== 16'h5000) $display("FAIL t3_attack got=%h exp=5000", level); else passed++;
      gate = 1'b0;
      tick();
      total++; if (level !== 16'h5000) $display("FAIL t3_hold got=%h exp=5000", level); else passed++;
      repeat (19) tick();
      total++; if (level !== 16'h0400) $display("FAIL t3_rel19 got=%h exp=0400", level); else passed++;
      tick();
      total++; if (level !== 16'h0 || busy !== 1'b0) $display("FAIL t3_rel20 level=%h busy=%b exp=0000/0", level, busy); else passed++;
   endtask

   task automatic test_retrigger();
      bit done;
      gate = 1'b1;
      tick();
      repeat (5) tick();
      gate = 1'b0;
      tick();
      wr(5'd28, 32'h0000_0100);
      total++; if (level !== 16'h4C00) $display("FAIL t4_rel_wr got=%h exp=4C00", level); else passed++;
      repeat (7) tick();
      total++; if (level !== 16'h3000) $display("FAIL t4_rel got=%h exp=3000", level); else passed++;
      gate = 1'b1;
      tick();
      total++; if (level !== 16'h3000 || busy !== 1'b1) $display("FAIL t4_retrig level=%h busy=%b exp=3000/1", level, busy); else passed++;
      tick();
      total++; if (level !== 16'h3100) $display("FAIL t4_attack got=%h exp=3100", level); else passed++;
      gate = 1'b0;
      tick();
      total++; if (level !== 16'h3100) $display("FAIL t4_rel_hold got=%h exp=3100", level); else passed++;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         if (!busy) done = 1'b1;
      end
      total++; if (!done || level !== 16'h0) $display("FAIL t4_idle done=%b level=%h exp=1/0000", done, level); else passed++;
      wr(5'd28, 32'h0000_1000);
   endtask

   task automatic test_sustain_write();
      gate = 1'b1;
      tick();
      repeat (16) tick();
      repeat (16) tick();
      total++; if (level !== 16'h8000) $display("FAIL t5_sustain got=%h exp=8000", level); else passed++;
      env_in = 24'h800000;
      tick();
      total++; if (env_out !== 24'hC00000) $display("FAIL t5_neg_out got=%h exp=C00000", env_out); else passed++;
      wr(5'd30, 32'h0000_4000);
      total++; if (level !== 16'h8000) $display("FAIL t5_s_wr_edge got=%h exp=8000", level); else passed++;
      tick();
      total++; if (level !== 16'h4000) $display("FAIL t5_s_track got=%h exp=4000", level); else passed++;
      wr(5'd5, 32'h0000_1234);
      tick();
      total++; if (level !== 16'h4000) $display("FAIL t5_foreign_addr got=%h exp=4000", level); else passed++;
      total++; if (env_out !== 24'hE00000) $display("FAIL t5_neg_out2 got=%h exp=E00000", env_out); else passed++;
   endtask

   task automatic test_async_reset();
      bit done;
      wr(5'd30, 32'h0000_8000);
      gate = 1'b0;
      env_in = 24'h100000;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         tick();
         if (!busy) done = 1'b1;
      end
      total++; if (!done) $display("FAIL t6_idle_timeout busy=%b exp=0", busy); else passed++;
      gate = 1'b1;
      tick();
      repeat (16) tick();
      repeat (5) tick();
      total++; if (level !== 16'hD7FF) $display("FAIL t6_decay got=%h exp=D7FF", level); else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (env_out !== 24'h0 || level !== 16'h0 || busy !== 1'b0) $display("FAIL t6_async out=%h level=%h busy=%b exp=0/0/0", env_out, level, busy); else passed++;
      gate = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      gate = 1'b1;
      tick();
      tick();
      total++; if (level !== 16'hFFFF) $display("FAIL t6_a_default got=%h exp=FFFF", level); else passed++;
      tick();
      total++; if (level !== 16'hFFFF) $display("FAIL t6_sd_default got=%h exp=FFFF", level); else passed++;
      gate = 1'b0;
      tick();
      tick();
      total++; if (level !== 16'h0 || busy !== 1'b0) $display("FAIL t6_r_default level=%h busy=%b exp=0000/0", level, busy); else passed++;
   endtask

   initial begin
      test_reset();
      test_default_regs();
      test_adsr();
      test_early_release();
      test_retrigger();
      test_sustain_write();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
